// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// FSM state encoding, ALU opcodes shared with decode, and default widths.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [5:0] OP_MULT = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011;
    localparam logic [5:0] OP_MFHI = 6'b000100;
    localparam logic [5:0] OP_MFLO = 6'b000101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // True for the opcodes that start a multi-cycle operation.
    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // True for every opcode that must wait while an operation is in flight.
    function automatic logic needs_hilo(input logic [5:0] op);
        return is_muldiv(op) || (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned multiply / divide datapath.
// The accumulator layout is shared by both operations:
//   multiply: {partial product high, multiplier bits not yet consumed}
//   divide:   {partial remainder, dividend bits not yet consumed / quotient}
// opnd_i is the multiplicand or the divisor magnitude.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               borrow;
    logic [2*WIDTH-1:0] div_acc;

    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift the whole product right, keeping the carry.
    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
    end

    // Restoring divide: bring down the next dividend bit, trial-subtract the
    // divisor, keep the difference only when it did not go negative. A zero
    // divisor never borrows, so the quotient fills with ones and the
    // remainder ends up holding the dividend magnitude.
    always_comb begin
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        borrow  = rem_sh < {1'b0, opnd_i};
        rem_sub = rem_sh[WIDTH-1:0] - opnd_i;
        div_acc = {(borrow ? rem_sh[WIDTH-1:0] : rem_sub), acc_i[WIDTH-2:0], ~borrow};
    end

    assign acc_o = is_div_i ? div_acc : mul_acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Operands are reduced to magnitudes at accept, iterated one bit per cycle
// in muldiv_core, and the signs are applied in FIX.
// Build option MULDIV_FAST_MUL_EN: multiply uses a single-cycle array
// multiplier and skips RUN; divide is unaffected.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic [5:0]       aluop,
    input  logic             uns,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg, start;
    logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
    logic [2*WIDTH-1:0] step_acc;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    assign busy  = (state_q != IDLE);
    assign stall = issue && busy && needs_hilo(aluop);
    assign start = issue && is_muldiv(aluop) && !stall;

    assign a_neg = !uns && op_a[WIDTH-1];
    assign b_neg = !uns && op_b[WIDTH-1];
    assign abs_a = a_neg ? -op_a : op_a;
    assign abs_b = b_neg ? -op_b : op_b;

    assign quot = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign done    = done_q;
    assign mf_data = (aluop == OP_MFHI) ? hi_q :
                     (aluop == OP_MFLO) ? lo_q : '0;

    // Next-state, datapath update and HI/LO write-back.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    opnd_d    = abs_b;
                    is_div_d  = (aluop == OP_DIV);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = (op_b == '0);
                    counter_d = '0;
                    state_d   = RUN;
`ifdef MULDIV_FAST_MUL_EN
                    if (aluop != OP_DIV) begin
                        acc_d   = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
                        state_d = FIX;
                    end
`endif
                end
            end
            RUN: begin
                acc_d     = step_acc;
                counter_d = counter_q + 1'b1;
                if (counter_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_res_q ? -quot : quot);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                done_d    = 1'b1;
                counter_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases, stall and
// reset scenarios, then randomized operations against an arithmetic model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         issue = 1'b0;
    logic [5:0]   aluop = 6'd0;
    logic         uns   = 1'b0;
    logic [W-1:0] op_a  = '0;
    logic [W-1:0] op_b  = '0;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo, mf_data;

    int n_vec = 0;
    int n_err = 0;

    muldiv_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .issue   (issue),
        .aluop   (aluop),
        .uns     (uns),
        .op_a    (op_a),
        .op_b    (op_b),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: returns {hi, lo}.
    function automatic logic [2*W-1:0] ref_result(input bit is_div, input bit u,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        if (!is_div) begin
            if (u) p = {32'd0, a} * {32'd0, b};
            else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (u) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges from accept to the first cycle showing done.
    function automatic int exp_lat(input bit is_div);
`ifdef MULDIV_FAST_MUL_EN
        return is_div ? W + 1 : 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
    endtask

    // Issue one mul/div from IDLE, wait for completion, check everything.
    task automatic run_op(input string tag, input bit is_div, input bit u,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] exp;
        int n;
        exp   = ref_result(is_div, u, a, b);
        issue = 1'b1;
        aluop = is_div ? OP_DIV : OP_MULT;
        uns   = u;
        op_a  = a;
        op_b  = b;
        tick;
        issue = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, ".latency"}, 32'(n), 32'(exp_lat(is_div)));
        check({tag, ".hi"}, hi, exp[2*W-1:W]);
        check({tag, ".lo"}, lo, exp[W-1:0]);
        tick;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        logic [2*W-1:0] exp;
        logic [W-1:0] ra, rb;
        bit rdiv, ru;

        // Reset state.
        issue = 1'b1;
        aluop = OP_MULT;
        repeat (3) tick;
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.done",  32'(done),  32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        issue = 1'b0;
        #2 reset = 1'b0;
        tick;

        // Directed corner cases.
        run_op("mult_neg",   1'b0, 1'b0, -32'sd3, 32'd7);
        run_op("multu_max",  1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        run_op("div_neg",    1'b1, 1'b0, -32'sd7, 32'd2);
        run_op("divu",       1'b1, 1'b1, 32'd100, 32'd7);
        run_op("div_zero",   1'b1, 1'b0, 32'd5, 32'd0);
        run_op("div_zero_n", 1'b1, 1'b0, -32'sd9, 32'd0);
        run_op("div_ovf",    1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Ops that are not mul/div, and bubbles, leave HI/LO alone.
        exp   = {hi, lo};
        issue = 1'b1;
        aluop = 6'b000000;
        op_a  = 32'd11;
        op_b  = 32'd13;
        tick;
        aluop = OP_MFHI;
        tick;
        issue = 1'b0;
        aluop = OP_MULT;
        tick;
        check("ignore.busy", 32'(busy), 32'd0);
        check("ignore.hi", hi, exp[2*W-1:W]);
        check("ignore.lo", lo, exp[W-1:0]);

        // MFHI right behind a MULT stalls until done and sees the new HI.
        exp   = ref_result(1'b0, 1'b0, 32'h1234_5678, -32'sd99);
        issue = 1'b1;
        aluop = OP_MULT;
        uns   = 1'b0;
        op_a  = 32'h1234_5678;
        op_b  = -32'sd99;
        tick;
        aluop = OP_MFHI;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("mfhi.stall_cycles", 32'(n), 32'(exp_lat(1'b0)));
        check("mfhi.done", 32'(done), 32'd1);
        check("mfhi.data", mf_data, exp[2*W-1:W]);
        aluop = OP_MFLO;
        #1;
        check("mflo.data", mf_data, exp[W-1:0]);
        issue = 1'b0;
        tick;

        // Back-to-back MULT: the second is held, then accepted in the done cycle.
        issue = 1'b1;
        aluop = OP_MULT;
        uns   = 1'b1;
        op_a  = 32'd6;
        op_b  = 32'd7;
        tick;
        ra   = 32'hDEAD_BEEF;
        rb   = 32'h0BAD_F00D;
        exp  = ref_result(1'b0, 1'b1, ra, rb);
        op_a = ra;
        op_b = rb;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("b2b.stall_cycles", 32'(n), 32'(exp_lat(1'b0)));
        check("b2b.first_lo", lo, 32'd42);
        tick;
        issue = 1'b0;
        check("b2b.second_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b.latency", 32'(n), 32'(exp_lat(1'b0)));
        check("b2b.hi", hi, exp[2*W-1:W]);
        check("b2b.lo", lo, exp[W-1:0]);
        tick;

        // Asynchronous reset ten cycles into a DIV.
        issue = 1'b1;
        aluop = OP_DIV;
        uns   = 1'b0;
        op_a  = -32'sd1000;
        op_b  = 32'd3;
        tick;
        repeat (10) tick;
        #2 reset = 1'b1;
        #1;
        check("arst.busy",  32'(busy),  32'd0);
        check("arst.stall", 32'(stall), 32'd0);
        check("arst.done",  32'(done),  32'd0);
        check("arst.hi", hi, 32'd0);
        check("arst.lo", lo, 32'd0);
        issue = 1'b0;
        #1 reset = 1'b0;
        tick;
        run_op("post_rst_multu", 1'b0, 1'b1, 32'd3, 32'd4);

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ru   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
                3: rb = 32'(int'($urandom_range(0, 31)) - 16);
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rdiv, ru, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
